tt_window_scheduler: RTL and testbench

Time-triggered receive-window scheduler that drives the table-load interface of `check_receive_window`. It holds a software-configured table of up to DEPTH receive-window entries, expressed as offsets within a repeating schedule cycle. Against `in_global_time`, it issues one entry at a time (port, buffer, absolute window start and end, flow id, length) whenever the checker reports `table_rdy`. Entries are walked in index order, the table wraps each cycle, and late entries are skipped and flagged.

---
 rtl/tt_window_scheduler_pkg.sv | 17 +
 rtl/tt_window_scheduler_if.sv | 23 ++
 rtl/tt_window_scheduler_table.sv | 32 +++
 rtl/tt_window_scheduler.sv | 130 +++++++++++++
 tb/tb_tt_window_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_window_scheduler_pkg.sv
// tt_sched_pkg: shared widths, FSM state encoding and table entry layout for tt_window_scheduler
package tt_sched_pkg;
   localparam int TIME_W = 64;
   localparam int ID_W = 16;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ISSUE, S_GUARD} state_t;
   // en is the MSB so the table can keep it in a separately reset vector
   typedef struct packed {
      logic en;
      logic [ID_W-1:0] port;
      logic [ID_W-1:0] buffer;
      logic [TIME_W-1:0] win_start;
      logic [TIME_W-1:0] win_end;
      logic [ID_W-1:0] flow_id;
      logic [ID_W-1:0] length;
   } entry_t;
   localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/tt_window_scheduler_if.sv
// tt_window_scheduler_if: table-load bus between the scheduler (master) and the receive-window checker (slave)
//   table_rdy       checker ready for an entry
//   table_wr        single-cycle entry strobe
//   port_number, buffer_number, window_start, window_end, flow_id, tt_length  entry data
interface tt_window_scheduler_if;
   import tt_sched_pkg::*;
   logic table_rdy;
   logic table_wr;
   logic [ID_W-1:0] port_number;
   logic [ID_W-1:0] buffer_number;
   logic [TIME_W-1:0] window_start;
   logic [TIME_W-1:0] window_end;
   logic [ID_W-1:0] flow_id;
   logic [ID_W-1:0] tt_length;
   modport master (
      input table_rdy,
      output table_wr, port_number, buffer_number, window_start, window_end, flow_id, tt_length
   );
   modport slave (
      output table_rdy,
      input table_wr, port_number, buffer_number, window_start, window_end, flow_id, tt_length
   );
endinterface

// File: rtl/tt_window_scheduler_table.sv
// tt_sched_table: DEPTH-entry register file, one write port, one synchronous read port, read-before-write
//   clk, rst          clock, async active-high reset (clears only the en bits and the read register)
//   we, waddr, wdata  write port
//   re, raddr, rdata  registered read port; rdata updates only when re is high
module tt_sched_table
   import tt_sched_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic we,
   input  logic [AW-1:0] waddr,
   input  entry_t wdata,
   input  logic re,
   input  logic [AW-1:0] raddr,
   output entry_t rdata
);
   logic [ENTRY_W-2:0] mem [DEPTH];
   logic [DEPTH-1:0] en;
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata[ENTRY_W-2:0];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         en <= '0;
         rdata <= '0;
      end else begin
         if (we) en[waddr] <= wdata.en;
         if (re) rdata <= {en[raddr], mem[raddr]};
      end
endmodule

// File: rtl/tt_window_scheduler.sv
// tt_window_scheduler: walks a cyclic table of receive windows and issues each one to the checker in time
//   clk, rst           clock, async active-high reset
//   in_enable          run the scheduler
//   in_global_time     synchronized global time
//   in_cfg_*           table write port and entry count
//   bus                table-load master (table_rdy in, entry strobe and data out)
//   out_index          current entry index
//   out_miss           pulse when an entry is skipped as late
//   out_busy           state is not IDLE
module tt_window_scheduler
   import tt_sched_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LEAD = 8,
   parameter logic [TIME_W-1:0] CYCLE_LEN = 64'd1000000,
   parameter int GUARD = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic in_enable,
   input  logic [TIME_W-1:0] in_global_time,
   input  logic in_cfg_wr,
   input  logic [AW-1:0] in_cfg_addr,
   input  logic in_cfg_en,
   input  logic [ID_W-1:0] in_cfg_port,
   input  logic [ID_W-1:0] in_cfg_buffer,
   input  logic [TIME_W-1:0] in_cfg_start,
   input  logic [TIME_W-1:0] in_cfg_end,
   input  logic [ID_W-1:0] in_cfg_flow_id,
   input  logic [ID_W-1:0] in_cfg_length,
   input  logic [AW:0] in_cfg_count,
   tt_window_scheduler_if.master bus,
   output logic [AW-1:0] out_index,
   output logic out_miss,
   output logic out_busy
);
   state_t state;
   logic [TIME_W-1:0] base;
   logic [AW-1:0] index;
   logic [7:0] gcnt;
   entry_t wdata;
   entry_t ent;
   logic [AW:0] cnt;
   logic wrap;
   logic [AW-1:0] index_n;
   logic [TIME_W-1:0] base_n;
   logic [TIME_W-1:0] abs_start;
   logic [TIME_W-1:0] abs_end;
   logic skip;
   logic late;
   logic go;
   assign wdata = '{en: in_cfg_en, port: in_cfg_port, buffer: in_cfg_buffer, win_start: in_cfg_start,
                    win_end: in_cfg_end, flow_id: in_cfg_flow_id, length: in_cfg_length};
   tt_sched_table #(.DEPTH(DEPTH)) u_table (
      .clk(clk),
      .rst(rst),
      .we(in_cfg_wr),
      .waddr(in_cfg_addr),
      .wdata(wdata),
      .re(state == S_LOAD),
      .raddr(index),
      .rdata(ent)
   );
   assign cnt = in_cfg_count > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : in_cfg_count;
   // index >= count also wraps, so a lowered count takes effect at the next advance
   assign wrap = cnt == '0 || {1'b0, index} >= cnt - 1'b1;
   assign index_n = wrap ? '0 : index + 1'b1;
   assign base_n = wrap ? base + CYCLE_LEN : base;
   // entry read in LOAD is held in the table's read register for the whole WAIT
   assign abs_start = base + ent.win_start;
   assign abs_end = base + ent.win_end;
   assign skip = !ent.en || ent.win_end < ent.win_start;
   assign late = in_global_time > abs_end;
   assign go = in_global_time + TIME_W'(LEAD) >= abs_start && bus.table_rdy;
   assign out_index = index;
   assign out_busy = state != S_IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_IDLE;
         base <= '0;
         index <= '0;
         gcnt <= '0;
         out_miss <= 1'b0;
         bus.table_wr <= 1'b0;
         bus.port_number <= '0;
         bus.buffer_number <= '0;
         bus.window_start <= '0;
         bus.window_end <= '0;
         bus.flow_id <= '0;
         bus.tt_length <= '0;
      end else begin
         out_miss <= 1'b0;
         bus.table_wr <= 1'b0;
         if (!in_enable && state != S_ISSUE) state <= S_IDLE;
         else case (state)
            S_IDLE: if (cnt != '0) begin
               state <= S_LOAD;
               base <= in_global_time;
               index <= '0;
            end
            S_LOAD: state <= S_WAIT;
            S_WAIT: if (skip || late) begin
               out_miss <= !skip;
               state <= S_LOAD;
               index <= index_n;
               base <= base_n;
            end else if (go) begin
               state <= S_ISSUE;
               bus.table_wr <= 1'b1;
               bus.port_number <= ent.port;
               bus.buffer_number <= ent.buffer;
               bus.window_start <= abs_start;
               bus.window_end <= abs_end;
               bus.flow_id <= ent.flow_id;
               bus.tt_length <= ent.length;
            end
            S_ISSUE: begin
               state <= in_enable ? S_GUARD : S_IDLE;
               gcnt <= '0;
            end
            S_GUARD: if (gcnt == 8'(GUARD - 1)) begin
               state <= S_LOAD;
               index <= index_n;
               base <= base_n;
            end else gcnt <= gcnt + 1'b1;
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_tt_window_scheduler.sv
// tb_tt_window_scheduler: directed scenarios plus randomized tables checked against an event-order model
module tb_tt_window_scheduler;
   import tt_sched_pkg::*;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam int LEAD = 8;
   localparam int GUARD = 2;
   localparam logic [63:0] CYC = 64'd1000000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_enable = 1'b0;
   logic [63:0] gt = '0;
   logic in_cfg_wr = 1'b0;
   logic [AW-1:0] in_cfg_addr = '0;
   logic in_cfg_en = 1'b0;
   logic [15:0] in_cfg_port = '0, in_cfg_buffer = '0, in_cfg_flow_id = '0, in_cfg_length = '0;
   logic [63:0] in_cfg_start = '0, in_cfg_end = '0;
   logic [AW:0] in_cfg_count = '0;
   logic [AW-1:0] out_index;
   logic out_miss, out_busy;
   tt_window_scheduler_if bus();
   tt_window_scheduler #(.DEPTH(DEPTH), .LEAD(LEAD), .CYCLE_LEN(CYC), .GUARD(GUARD)) dut (
      .clk(clk), .rst(rst), .in_enable(in_enable), .in_global_time(gt),
      .in_cfg_wr(in_cfg_wr), .in_cfg_addr(in_cfg_addr), .in_cfg_en(in_cfg_en),
      .in_cfg_port(in_cfg_port), .in_cfg_buffer(in_cfg_buffer), .in_cfg_start(in_cfg_start),
      .in_cfg_end(in_cfg_end), .in_cfg_flow_id(in_cfg_flow_id), .in_cfg_length(in_cfg_length),
      .in_cfg_count(in_cfg_count), .bus(bus), .out_index(out_index), .out_miss(out_miss), .out_busy(out_busy)
   );
   always #5 clk = ~clk;
   int n_pass = 0, n_total = 0;
   int nmiss = 0, tickn = 0;
   logic [63:0] st;
   logic srdy;
   // reference table and schedule walker: which entry comes next and in which cycle
   logic m_en [DEPTH];
   logic [63:0] m_s [DEPTH], m_e [DEPTH];
   logic [15:0] m_p [DEPTH], m_b [DEPTH], m_f [DEPTH], m_l [DEPTH];
   int mi, mcnt;
   logic [63:0] mb;
   function automatic bit m_valid(int i);
      return m_en[i] && m_e[i] >= m_s[i];
   endfunction
   task m_adv();
      if (mi >= mcnt - 1) begin
         mi = 0;
         mb += CYC;
      end else mi++;
   endtask
   task m_skip();
      for (int k = 0; k < DEPTH + 1 && !m_valid(mi); k++) m_adv();
   endtask
   // st/srdy are the time and ready values the DUT saw at the edge just passed
   task tick();
      @(posedge clk);
      #1;
      st = gt;
      srdy = bus.table_rdy;
      tickn++;
   endtask
   task do_reset();
      rst = 1'b1;
      in_enable = 1'b0;
      in_cfg_wr = 1'b0;
      bus.table_rdy = 1'b0;
      gt = '0;
      for (int i = 0; i < DEPTH; i++) m_en[i] = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask
   task wr_entry(input int a, input bit en, input logic [15:0] p, input logic [15:0] b,
                 input logic [63:0] s, input logic [63:0] e, input logic [15:0] f, input logic [15:0] l);
      in_cfg_wr = 1'b1;
      in_cfg_addr = AW'(a);
      in_cfg_en = en;
      in_cfg_port = p;
      in_cfg_buffer = b;
      in_cfg_start = s;
      in_cfg_end = e;
      in_cfg_flow_id = f;
      in_cfg_length = l;
      m_en[a] = en; m_p[a] = p; m_b[a] = b; m_s[a] = s; m_e[a] = e; m_f[a] = f; m_l[a] = l;
      tick();
      in_cfg_wr = 1'b0;
   endtask
   task start_run(input logic [63:0] g, input int cnt);
      gt = g;
      in_cfg_count = (AW+1)'(cnt);
      in_enable = 1'b1;
      tick();
      mb = g;
      mi = 0;
      mcnt = cnt > DEPTH ? DEPTH : cnt;
   endtask
   task automatic wait_wr(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (out_miss) nmiss++;
         if (bus.table_wr) ok = 1'b1;
         else gt += 1;
      end
   endtask
   task test_reset();
      do_reset();
      n_total++; if (bus.table_wr !== 1'b0) $display("FAIL reset_wr got %b exp 0", bus.table_wr); else n_pass++;
      n_total++; if (out_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", out_busy); else n_pass++;
      n_total++; if (out_miss !== 1'b0) $display("FAIL reset_miss got %b exp 0", out_miss); else n_pass++;
      n_total++; if (out_index !== '0) $display("FAIL reset_index got %0d exp 0", out_index); else n_pass++;
      n_total++; if ({bus.window_start, bus.window_end, bus.flow_id, bus.port_number} !== '0)
         $display("FAIL reset_data got %0d/%0d exp 0", bus.window_start, bus.flow_id); else n_pass++;
   endtask
   task test_single();
      bit ok;
      do_reset();
      wr_entry(0, 1, 2, 1, 100, 200, 5, 64);
      bus.table_rdy = 1'b1;
      start_run(1000, 1);
      nmiss = 0;
      wait_wr(300, ok);
      n_total++; if (!ok) $display("FAIL single_issue got none exp table_wr"); else n_pass++;
      n_total++; if (st !== 64'd1092) $display("FAIL single_time got %0d exp 1092", st); else n_pass++;
      n_total++; if (bus.window_start !== 64'd1100 || bus.window_end !== 64'd1200)
         $display("FAIL single_window got %0d..%0d exp 1100..1200", bus.window_start, bus.window_end); else n_pass++;
      n_total++; if ({bus.port_number, bus.buffer_number, bus.flow_id, bus.tt_length} !== {16'd2, 16'd1, 16'd5, 16'd64})
         $display("FAIL single_fields got p%0d b%0d f%0d l%0d exp p2 b1 f5 l64", bus.port_number, bus.buffer_number, bus.flow_id, bus.tt_length); else n_pass++;
      n_total++; if (out_miss !== 1'b0) $display("FAIL single_nomiss got %b exp 0", out_miss); else n_pass++;
      tick();
      n_total++; if (bus.table_wr !== 1'b0) $display("FAIL single_pulse got %b exp 0", bus.table_wr); else n_pass++;
      n_total++; if (bus.window_start !== 64'd1100) $display("FAIL single_hold got %0d exp 1100", bus.window_start); else n_pass++;
      gt = 64'd1001000;
      wait_wr(300, ok);
      n_total++; if (!ok || bus.window_start !== 64'd1001100 || bus.window_end !== 64'd1001200)
         $display("FAIL single_wrap got ok=%b %0d..%0d exp 1001100..1001200", ok, bus.window_start, bus.window_end); else n_pass++;
      n_total++; if (st !== 64'd1001092) $display("FAIL single_wrap_time got %0d exp 1001092", st); else n_pass++;
      n_total++; if (nmiss !== 0) $display("FAIL single_misses got %0d exp 0", nmiss); else n_pass++;
   endtask
   task test_late();
      int nwr, nm;
      logic [63:0] mt;
      do_reset();
      wr_entry(0, 1, 2, 1, 100, 200, 5, 64);
      wr_entry(1, 1, 3, 2, 900, 950, 6, 64);
      bus.table_rdy = 1'b0;
      start_run(1000, 2);
      nwr = 0; nm = 0; mt = '0;
      for (int i = 0; i < 400 && gt < 64'd1250; i++) begin
         tick();
         if (bus.table_wr) nwr++;
         if (out_miss) begin nm++; mt = st; end
         gt += 1;
      end
      n_total++; if (nm !== 1) $display("FAIL late_miss_count got %0d exp 1", nm); else n_pass++;
      n_total++; if (nwr !== 0) $display("FAIL late_wr_count got %0d exp 0", nwr); else n_pass++;
      n_total++; if (mt !== 64'd1201) $display("FAIL late_miss_time got %0d exp 1201", mt); else n_pass++;
      n_total++; if (out_index !== AW'(1)) $display("FAIL late_index got %0d exp 1", out_index); else n_pass++;
   endtask
   task test_skip();
      bit ok;
      do_reset();
      wr_entry(0, 1, 1, 1, 100, 200, 10, 64);
      wr_entry(1, 0, 1, 1, 120, 220, 11, 64);
      wr_entry(2, 1, 1, 1, 80, 50, 12, 64);
      wr_entry(3, 1, 1, 1, 300, 400, 13, 64);
      bus.table_rdy = 1'b1;
      start_run(2000, 4);
      wait_wr(300, ok);
      n_total++; if (!ok || bus.flow_id !== 16'd10) $display("FAIL skip_first got ok=%b f%0d exp f10", ok, bus.flow_id); else n_pass++;
      nmiss = 0;
      tick();
      wait_wr(400, ok);
      n_total++; if (!ok || bus.flow_id !== 16'd13) $display("FAIL skip_next got ok=%b f%0d exp f13", ok, bus.flow_id); else n_pass++;
      n_total++; if (out_index !== AW'(3) || st !== 64'd2292) $display("FAIL skip_idx got i%0d t%0d exp i3 t2292", out_index, st); else n_pass++;
      n_total++; if (nmiss !== 0) $display("FAIL skip_miss got %0d exp 0", nmiss); else n_pass++;
   endtask
   task test_load_write();
      bit ok;
      do_reset();
      wr_entry(0, 1, 2, 1, 100, 200, 5, 64);
      bus.table_rdy = 1'b1;
      gt = 64'd1000;
      in_cfg_count = 1;
      in_enable = 1'b1;
      tick();
      n_total++; if (out_busy !== 1'b1) $display("FAIL lw_busy got %b exp 1", out_busy); else n_pass++;
      wr_entry(0, 1, 2, 1, 150, 250, 9, 64);
      wait_wr(300, ok);
      n_total++; if (!ok || bus.flow_id !== 16'd5 || bus.window_start !== 64'd1100)
         $display("FAIL lw_old got ok=%b f%0d s%0d exp f5 s1100", ok, bus.flow_id, bus.window_start); else n_pass++;
      tick();
      gt = 64'd1001000;
      wait_wr(300, ok);
      n_total++; if (!ok || bus.flow_id !== 16'd9 || bus.window_start !== 64'd1001150 || bus.window_end !== 64'd1001250)
         $display("FAIL lw_new got ok=%b f%0d s%0d exp f9 s1001150", ok, bus.flow_id, bus.window_start); else n_pass++;
   endtask
   task test_reset_mid();
      bit ok;
      do_reset();
      wr_entry(0, 1, 2, 1, 100, 200, 5, 64);
      bus.table_rdy = 1'b1;
      start_run(1000, 1);
      wait_wr(300, ok);
      n_total++; if (!ok) $display("FAIL rm_issue got none exp table_wr"); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (bus.table_wr !== 1'b0 || out_busy !== 1'b0) $display("FAIL rm_async got wr%b busy%b exp 0 0", bus.table_wr, out_busy); else n_pass++;
      n_total++; if ({bus.window_start, bus.window_end, bus.flow_id, bus.tt_length, bus.port_number, bus.buffer_number} !== '0)
         $display("FAIL rm_data got s%0d f%0d exp 0", bus.window_start, bus.flow_id); else n_pass++;
      tick();
      rst = 1'b0;
      nmiss = 0;
      wait_wr(60, ok);
      n_total++; if (ok || nmiss !== 0) $display("FAIL rm_en_cleared got wr%b miss%0d exp 0 0", ok, nmiss); else n_pass++;
   endtask
   task test_disable();
      bit ok;
      do_reset();
      wr_entry(0, 1, 2, 1, 100, 200, 5, 64);
      bus.table_rdy = 1'b1;
      start_run(1000, 1);
      tick();
      tick();
      n_total++; if (out_busy !== 1'b1) $display("FAIL dis_busy got %b exp 1", out_busy); else n_pass++;
      in_enable = 1'b0;
      tick();
      n_total++; if (out_busy !== 1'b0) $display("FAIL dis_idle got %b exp 0", out_busy); else n_pass++;
      start_run(5000, 1);
      wait_wr(300, ok);
      n_total++; if (!ok || bus.window_start !== 64'd5100 || st !== 64'd5092)
         $display("FAIL dis_rebase got ok=%b s%0d t%0d exp s5100 t5092", ok, bus.window_start, st); else n_pass++;
   endtask
   task test_random();
      for (int run = 0; run < 4; run++) begin
         logic [63:0] g, s, e;
         int w, cnt, hold, last;
         bit wr, ms;
         do_reset();
         for (int a = 0; a < DEPTH; a++) begin
            s = 64'($urandom_range(20, 400));
            w = int'($urandom_range(0, 110)) - 20;
            if (a == 0 && w < 0) w = -w;
            e = w >= 0 ? s + 64'(w) : s - 64'(-w);
            wr_entry(a, a == 0 || $urandom_range(0, 4) != 0, 16'($urandom), 16'($urandom), s, e, 16'($urandom), 16'($urandom));
         end
         cnt = run == 0 ? 3 : ($urandom_range(0, 3) == 0 ? 20 : int'($urandom_range(1, 6)));
         g = 64'($urandom);
         bus.table_rdy = 1'b1;
         start_run(g, cnt);
         m_skip();
         hold = 0;
         last = -100;
         for (int i = 0; i < 8000 && mb < g + 3 * CYC; i++) begin
            tick();
            wr = bus.table_wr;
            ms = out_miss;
            n_total++; if (wr && ms) $display("FAIL rnd_both got wr=1 miss=1 exp exclusive"); else n_pass++;
            if (wr || ms) begin
               s = mb + m_s[mi];
               e = mb + m_e[mi];
               if (wr) begin
                  n_total++; if (out_index !== AW'(mi) || bus.window_start !== s || bus.window_end !== e)
                     $display("FAIL rnd_entry got i%0d %0d..%0d exp i%0d %0d..%0d", out_index, bus.window_start, bus.window_end, mi, s, e); else n_pass++;
                  n_total++; if ({bus.port_number, bus.buffer_number, bus.flow_id, bus.tt_length} !== {m_p[mi], m_b[mi], m_f[mi], m_l[mi]})
                     $display("FAIL rnd_fields got f%0d l%0d exp f%0d l%0d", bus.flow_id, bus.tt_length, m_f[mi], m_l[mi]); else n_pass++;
                  n_total++; if (!(st + LEAD >= s && st <= e && srdy))
                     $display("FAIL rnd_issue_time got t%0d rdy%b exp t in %0d..%0d rdy1", st, srdy, s - LEAD, e); else n_pass++;
                  n_total++; if (tickn - last < 3 + GUARD) $display("FAIL rnd_gap got %0d exp >=%0d", tickn - last, 3 + GUARD); else n_pass++;
                  last = tickn;
               end else begin
                  n_total++; if (!(st > e)) $display("FAIL rnd_miss_time got t%0d exp >%0d", st, e); else n_pass++;
               end
               m_adv();
               m_skip();
            end
            if (wr) begin
               bus.table_rdy = 1'b0;
               hold = $urandom_range(1, 8);
            end else if (hold > 0) begin
               hold--;
               if (hold == 0) bus.table_rdy = 1'b1;
            end else bus.table_rdy = $urandom_range(0, 7) != 0;
            if (gt < mb) gt = mb;
            else gt += 1;
         end
         n_total++; if (mb < g + 3 * CYC) $display("FAIL rnd_progress got base %0d exp >=%0d", mb, g + 3 * CYC); else n_pass++;
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_late();
      test_skip();
      test_load_write();
      test_reset_mid();
      test_disable();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
   initial begin
      #10000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
endmodule
